// File: rtl/hello_pkg.sv
// Shared constants and state encoding for the HELLO 7-segment stream checker.
package hello_pkg;

    // Segment codes {a,b,c,d,e,f,g}, active-low (0 = segment lit)
    localparam logic [6:0] SEG_H = 7'b1001000;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_L = 7'b1110001;
    localparam logic [6:0] SEG_O = 7'b0000001;

    localparam logic [2:0] CH_H   = 3'd0;
    localparam logic [2:0] CH_E   = 3'd1;
    localparam logic [2:0] CH_L   = 3'd2;
    localparam logic [2:0] CH_O   = 3'd3;
    localparam logic [2:0] CH_UNK = 3'd7;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        GOT_H  = 3'd1,
        GOT_E  = 3'd2,
        GOT_L1 = 3'd3,
        GOT_L2 = 3'd4
    } state_e;

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational 7-segment code to HELLO letter code decoder.
module seg7_char_decode
    import hello_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [6:0] seg_i,
    output logic [2:0] char_o
);

    logic [6:0] code;

    // Normalise to active-low so one constant table serves both polarities
    assign code = (ACTIVE_LOW != 0) ? seg_i : ~seg_i;

    always_comb begin
        char_o = CH_UNK;
        case (code)
            SEG_H:   char_o = CH_H;
            SEG_E:   char_o = CH_E;
            SEG_L:   char_o = CH_L;
            SEG_O:   char_o = CH_O;
            default: char_o = CH_UNK;
        endcase
    end

endmodule

// File: rtl/hello_seg_checker.sv
// Two-stage HELLO word checker on a 7-segment bus: decode register, then word FSM.
// Optional error counter enabled by defining HELLO_CHK_ERRCNT_EN.
module hello_seg_checker
    import hello_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int LOCK_WORDS = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [6:0]       seg_in,
    input  logic             seg_valid,
    output logic [2:0]       char_out,
    output logic             char_valid,
    output logic             word_done,
    output logic             seq_err,
    output logic             locked,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0] LOCK_W = 4'(LOCK_WORDS);

    logic [2:0]       char_d;
    logic [2:0]       char_q;
    logic             char_vld_q;
    state_e           state_q;
    logic [2:0]       exp_ch;
    logic             mismatch;
    logic             complete;
    logic             word_done_q;
    logic             seq_err_q;
    logic             locked_q;
    logic [3:0]       clean_q;
    logic [CNT_W-1:0] wcnt_q;

    seg7_char_decode #(
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_decode (
        .seg_i (seg_in),
        .char_o(char_d)
    );

    // Stage 1: capture decoded letter; char_out holds across idle cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            char_q     <= CH_UNK;
            char_vld_q <= 1'b0;
        end else begin
            char_vld_q <= seg_valid;
            if (seg_valid) begin
                char_q <= char_d;
            end
        end
    end

    always_comb begin
        exp_ch = CH_H;
        case (state_q)
            GOT_H:   exp_ch = CH_E;
            GOT_E:   exp_ch = CH_L;
            GOT_L1:  exp_ch = CH_L;
            GOT_L2:  exp_ch = CH_O;
            default: exp_ch = CH_H;
        endcase
    end

    // HUNT never flags errors: it simply waits for an H
    assign mismatch = char_vld_q && (state_q != HUNT) && (char_q != exp_ch);
    assign complete = char_vld_q && (state_q == GOT_L2) && (char_q == CH_O);

    // Stage 2: word FSM with registered pulses, counters and lock status
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= HUNT;
            word_done_q <= 1'b0;
            seq_err_q   <= 1'b0;
            locked_q    <= 1'b0;
            clean_q     <= 4'd0;
            wcnt_q      <= '0;
        end else begin
            word_done_q <= complete;
            seq_err_q   <= mismatch;

            if (char_vld_q) begin
                if (mismatch) begin
                    state_q <= (char_q == CH_H) ? GOT_H : HUNT;
                end else begin
                    case (state_q)
                        HUNT:    if (char_q == CH_H) state_q <= GOT_H;
                        GOT_H:   state_q <= GOT_E;
                        GOT_E:   state_q <= GOT_L1;
                        GOT_L1:  state_q <= GOT_L2;
                        GOT_L2:  state_q <= HUNT;
                        default: state_q <= HUNT;
                    endcase
                end
            end

            if (complete) begin
                wcnt_q <= wcnt_q + 1'b1;
            end

            if (mismatch) begin
                clean_q <= 4'd0;
            end else if (complete && (clean_q < LOCK_W)) begin
                clean_q <= clean_q + 4'd1;
            end

            // Lock follows the word_done pulse by one cycle; an error always wins
            if (mismatch) begin
                locked_q <= 1'b0;
            end else if (word_done_q && (clean_q == LOCK_W)) begin
                locked_q <= 1'b1;
            end
        end
    end

`ifdef HELLO_CHK_ERRCNT_EN
    logic [CNT_W-1:0] ecnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ecnt_q <= '0;
        end else if (mismatch && (ecnt_q != {CNT_W{1'b1}})) begin
            ecnt_q <= ecnt_q + 1'b1;
        end
    end

    assign err_count = ecnt_q;
`else
    assign err_count = '0;
`endif

    assign char_out   = char_q;
    assign char_valid = char_vld_q;
    assign word_done  = word_done_q;
    assign seq_err    = seq_err_q;
    assign locked     = locked_q;
    assign word_count = wcnt_q;

endmodule

// File: tb/tb_hello_seg_checker.sv
// Scoreboard bench for hello_seg_checker: stimulus pushes reference results, a monitor pops and compares.
module tb_hello_seg_checker;

    localparam int CNT_W = 8;
    localparam int LOCK  = 2;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [6:0]       seg_in = 7'h7F;
    logic             seg_valid = 1'b0;
    logic [2:0]       char_out;
    logic             char_valid;
    logic             word_done;
    logic             seq_err;
    logic             locked;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] err_count;

    hello_seg_checker #(
        .CNT_W(CNT_W),
        .ACTIVE_LOW(1),
        .LOCK_WORDS(LOCK)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .char_out  (char_out),
        .char_valid(char_valid),
        .word_done (word_done),
        .seq_err   (seq_err),
        .locked    (locked),
        .word_count(word_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int done;
        int err;
        int lk_after;
        int wc;
        int ec;
    } item_t;

    item_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: letters matched so far in the current word
    int m_pos = 0;
    int m_clean = 0;
    int m_locked = 0;
    int m_wc = 0;
    int m_ec = 0;
    int word_ref[5] = '{0, 1, 2, 2, 3};

    // Monitor-side view of what the registered outputs should currently show
    int    pend = 0;
    item_t pend_it;
    int    last_char = 7;
    int    lk_state = 0;
    int    wc_state = 0;
    int    ec_state = 0;

    localparam logic [6:0] H = 7'b1001000;
    localparam logic [6:0] E = 7'b0110000;
    localparam logic [6:0] L = 7'b1110001;
    localparam logic [6:0] O = 7'b0000001;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_char(input logic [6:0] s);
        if (s == 7'b1001000) return 0;
        if (s == 7'b0110000) return 1;
        if (s == 7'b1110001) return 2;
        if (s == 7'b0000001) return 3;
        return 7;
    endfunction

    task automatic send(input logic [6:0] s);
        item_t it;
        int c;
        c = ref_char(s);
        it.ch = c;
        it.done = 0;
        it.err = 0;
        if (m_pos == 0) begin
            if (c == 0) m_pos = 1;
        end else if (c == word_ref[m_pos]) begin
            m_pos++;
            if (m_pos == 5) begin
                m_pos = 0;
                it.done = 1;
                m_wc = (m_wc + 1) % (1 << CNT_W);
                if (m_clean < LOCK) m_clean++;
                if (m_clean >= LOCK) m_locked = 1;
            end
        end else begin
            it.err = 1;
            m_clean = 0;
            m_locked = 0;
            if (m_ec < (1 << CNT_W) - 1) m_ec++;
            m_pos = (c == 0) ? 1 : 0;
        end
        it.lk_after = m_locked;
        it.wc = m_wc;
`ifdef HELLO_CHK_ERRCNT_EN
        it.ec = m_ec;
`else
        it.ec = 0;
`endif
        q.push_back(it);
        seg_in = s;
        seg_valid = 1'b1;
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        seg_in = 7'h7F;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hello();
        send(H); send(E); send(L); send(L); send(O);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #2;
        chk("rst_char_out", char_out, 7);
        chk("rst_char_valid", char_valid, 0);
        chk("rst_word_done", word_done, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_locked", locked, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_err_count", err_count, 0);
        q.delete();
        pend = 0;
        last_char = 7;
        lk_state = 0;
        wc_state = 0;
        ec_state = 0;
        m_pos = 0;
        m_clean = 0;
        m_locked = 0;
        m_wc = 0;
        m_ec = 0;
        idle(3);
        rstn = 1'b1;
        idle(1);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (pend != 0) begin
                chk("word_done", word_done, pend_it.done);
                chk("seq_err", seq_err, pend_it.err);
                chk("word_count", word_count, pend_it.wc);
                chk("err_count", err_count, pend_it.ec);
                chk("locked", locked, pend_it.err ? 0 : lk_state);
                lk_state = pend_it.lk_after;
                wc_state = pend_it.wc;
                ec_state = pend_it.ec;
            end else begin
                chk("word_done_idle", word_done, 0);
                chk("seq_err_idle", seq_err, 0);
                chk("word_count_idle", word_count, wc_state);
                chk("err_count_idle", err_count, ec_state);
                chk("locked_idle", locked, lk_state);
            end
            pend = 0;
            if (char_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_char_valid", 1, 0);
                end else begin
                    pend_it = q.pop_front();
                    pend = 1;
                    chk("char_out", char_out, pend_it.ch);
                    last_char = pend_it.ch;
                end
            end else begin
                chk("char_hold", char_out, last_char);
            end
        end
    end

    initial begin
        int n;
        do_reset();

        // Single clean word, then a second back-to-back to reach lock
        hello();
        idle(3);
        hello();
        hello();
        idle(4);

        // Missing second L after lock
        send(H); send(E); send(L); send(O);
        idle(3);

        // Resync on an unexpected H
        send(H); send(E); send(H); send(E); send(L); send(L); send(O);
        idle(3);

        // Alternating valid/idle with seg_in forced to all-ones in the gaps
        send(H); idle(1); send(E); idle(1); send(L); idle(1);
        send(L); idle(1); send(O); idle(3);

        // Reset mid-word discards the partial word
        send(H); send(E); send(L);
        idle(3);
        do_reset();
        hello();
        idle(3);

        // Randomised words with occasional corruption and gaps
        for (int w = 0; w < 60; w++) begin
            for (int k = 0; k < 5; k++) begin
                logic [6:0] s;
                case (k)
                    0: s = H;
                    1: s = E;
                    2: s = L;
                    3: s = L;
                    default: s = O;
                endcase
                if ($urandom_range(0, 15) == 0) begin
                    case ($urandom_range(0, 4))
                        0: s = H;
                        1: s = E;
                        2: s = L;
                        3: s = O;
                        default: s = 7'($urandom);
                    endcase
                end
                send(s);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end

        n = 0;
        while ((q.size() != 0 || pend != 0) && n < 20) begin
            idle(1);
            n++;
        end
        chk("drain_timeout", n < 20 ? 1 : 0, 1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
